// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : ALU op codes, decode class/funct codes, issue-entry and FSM types.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_BAD = 3'b111;

  localparam logic [1:0] CLS_ADD  = 2'b00;
  localparam logic [1:0] CLS_SUB  = 2'b01;
  localparam logic [1:0] CLS_RTYP = 2'b10;
  localparam logic [1:0] CLS_RSVD = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [2:0]       op;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
// ----------------------------------------------------------------------------
// alu_issue_stage_if : decode-side and ALU-side handshake bundle of the stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_issue_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_class;
  logic [5:0]        in_funct;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic              illegal;

  modport master (
    output in_valid, in_a, in_b, in_class, in_funct, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_class, in_funct, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ----------------------------------------------------------------------------
// alu_op_decode : combinational class/funct to 3-bit ALU op plus illegal flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       illegal
);

  always_comb begin
    op      = OP_BAD;
    illegal = 1'b1;
    case (cls)
      CLS_ADD: begin op = OP_ADD; illegal = 1'b0; end
      CLS_SUB: begin op = OP_SUB; illegal = 1'b0; end
      CLS_RTYP: begin
        illegal = 1'b0;
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_SLT:  op = OP_SLT;
          default: begin op = OP_BAD; illegal = 1'b1; end
        endcase
      end
      default: begin op = OP_BAD; illegal = 1'b1; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage : registered ALU issue stage, 2-entry skid buffer, flush.
// Optional ALU_ISSUE_STATS_EN adds saturating issue/stall counters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef ALU_ISSUE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  alu_issue_stage_if.slave  bus
`ifdef ALU_ISSUE_STATS_EN
  , output logic [CNT_W-1:0] stat_issued
  , output logic [CNT_W-1:0] stat_stall
`endif
);

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  entry_t new_entry;
  logic   out_valid;
  logic   accept;
  logic   pop;

  alu_op_decode u_dec (
    .cls     (bus.in_class),
    .funct   (bus.in_funct),
    .op      (new_entry.op),
    .illegal (new_entry.illegal)
  );

  assign new_entry.a = bus.in_a[DATA_W-1:0];
  assign new_entry.b = bus.in_b[DATA_W-1:0];

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = new_entry;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_d = new_entry;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = new_entry;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush discards everything; data is left untouched so the ALU inputs stay quiet.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.alu_a     = main_q.a;
  assign bus.alu_b     = main_q.b;
  assign bus.alu_op    = main_q.op;
  assign bus.illegal   = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
  logic [CNT_W-1:0] stat_issued_q, stat_issued_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  // A pop in the flush cycle is still consumed downstream, so it is counted.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (pop && !main_q.illegal && (stat_issued_q != {CNT_W{1'b1}}))
      stat_issued_d = stat_issued_q + 1'b1;
    if (out_valid && !bus.out_ready && (stat_stall_q != {CNT_W{1'b1}}))
      stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the 32-bit ALU.
- Accepts decoded operands plus a class/funct pair from decode over a valid/ready handshake, translates them to the 3-bit ALU operation code, and holds them stable on the ALU inputs.
- A 2-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush kills in-flight entries on branch redirect.

Parameters:
- DATA_W, 32, operand width; must match ALU width.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  decode presents an op
- in_ready  output  1  stage can accept; registered
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_class  input  2  00 = add (ld/st address), 01 = sub (branch compare), 10 = R-type (use funct), 11 = reserved
- in_funct  input  6  R-type function field
- out_valid  output  1  ALU inputs hold a valid op
- out_ready  input  1  downstream consumes op this cycle
- alu_a  output  DATA_W  to ALU A
- alu_b  output  DATA_W  to ALU B
- alu_op  output  3  to ALU operation select
- illegal  output  1  qualifies out_valid: current op has unsupported class/funct

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid = 0, in_ready = 1, alu_a = 0, alu_b = 0, alu_op = 3'b000, illegal = 0.
- Decode is combinational on input, and the result is stored with the entry:
  - class 00 -> 000 (add); class 01 -> 001 (sub); class 11 -> 111 with illegal = 1.
  - class 10 with funct 100000 -> 000, 100010 -> 001, 100100 -> 010 (and), 100101 -> 011 (or), 101010 -> 101 (slt).
  - Any other funct -> 111 with illegal = 1. The ALU outputs 0 for 111.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - Outputs are driven only from the main register; never combinational from inputs. Latency is 1 cycle from accept to out_valid.
  - While out_valid = 1 and out_ready = 0, all outputs hold stable.
- States: EMPTY (no entries), ONE (main valid), TWO (main + skid valid).
  - EMPTY: accept -> ONE, entry loads into main.
  - ONE:
    - accept and pop -> ONE, new entry loads into main.
    - accept only -> TWO, entry loads into skid; in_ready drops next cycle.
    - pop only -> EMPTY.
  - TWO: in_ready = 0, so no accept is possible.
    - pop -> ONE, skid moves to main, and in_ready rises next cycle.
    - otherwise hold.
- in_ready = 1 exactly in EMPTY and ONE.
- Flush:
  - Next state is EMPTY; out_valid = 0 and in_ready = 1 next cycle.
  - Flush overrides a same-cycle accept (entry discarded) and a same-cycle pop (pop still counts as consumed downstream).
  - Data registers need not clear on flush; alu_op and illegal are not required to change.
- Reset mid-operation: all entries are lost immediately; there is no recovery.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, adds outputs stat_issued [CNT_W-1:0] (counts pops of legal ops) and stat_stall [CNT_W-1:0] (counts cycles with out_valid && !out_ready).
- Both counters:
  - saturate at all-ones;
  - reset to 0 on rst_n;
  - are not cleared by flush.
- When undefined, these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU op localparams OP_ADD = 000, OP_SUB = 001, OP_AND = 010, OP_OR = 011, OP_SLT = 101, OP_BAD = 111;
  - class codes;
  - funct codes;
  - entry typedef {a, b, op, illegal}.
- The ALU uses the same op constants from the package.
- One natural sub-module: alu_op_decode (combinational class/funct -> op, illegal), reusable by other pipeline stages.

Test Plan:
- Reset:
  - Stimulus: rst_n low with in_valid = 1.
  - Required: out_valid = 0, in_ready = 1, alu_op = 000 throughout.
  - Then release reset, send class 10 / funct 101010 with a = 5, b = 9.
  - Required: the next cycle shows out_valid = 1, alu_op = 101, alu_a = 5, alu_b = 9, illegal = 0.
- Back-to-back:
  - Stimulus: out_ready held 1, 8 consecutive ops alternating add/sub/and/or.
  - Required: in_ready stays 1, one pop per cycle, ops emerge in order with 1-cycle latency.
- Backpressure:
  - Stimulus: out_ready = 0 while 3 ops are offered.
  - Required: first op goes to main, second to skid, in_ready = 0 the following cycle, and the third op is held by the source.
  - Then raise out_ready.
  - Required: order op1, op2, op3 with no loss and no duplication.
- Illegal:
  - Stimulus: class 10 funct 000111, then class 11.
  - Required: both show alu_op = 111 and illegal = 1.
- Flush:
  - Stimulus: in state TWO, assert flush together with in_valid.
  - Required: next cycle out_valid = 0, in_ready = 1, and the flushed-cycle op never appears at the output.
- Stats (with ALU_ISSUE_STATS_EN):
  - Stimulus: 4 legal pops, 1 illegal pop, 3 stall cycles.
  - Required: stat_issued = 4, stat_stall = 3.
  - Force near-saturation with CNT_W = 2.
  - Required: stat_stall holds at 3.
